// File: rtl/qtable_scheduler_pkg.sv
// Shared definitions for the Q-table update scheduler: FSM state encoding,
// the received-packet record and the packet-type constants.
package qtable_scheduler_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GRANT = 2'd3
  } state_e;

  // Packets of this type are dropped at the input and never buffered.
  localparam logic [2:0] PKT_TYPE_INVALID = 3'b000;

  // Field width of the packet record at the default configuration.
  localparam int PKT_WORD_W = 16;

  // Packet record (99 bits at the default width).
  typedef struct packed {
    logic [PKT_WORD_W-1:0] sourceID;
    logic [PKT_WORD_W-1:0] sourceHops;
    logic [PKT_WORD_W-1:0] clusterID;
    logic [PKT_WORD_W-1:0] energyLeft;
    logic [PKT_WORD_W-1:0] qValue;
    logic [PKT_WORD_W-1:0] knownCH;
    logic [2:0]            ptype;
  } pkt_t;

endpackage

// File: rtl/pkt_fifo.sv
// Packet buffer: circular FIFO with a combinational head and a synchronous
// active-low reset on the pointers and count (storage itself is not reset).
module pkt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 99
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_wr, do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_rd     = rd_en_i && !empty_o;
  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_wr     = wr_en_i && (!full || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/qtable_scheduler.sv
// Q-table update scheduler: buffers received packets, issues them one at a
// time to the update datapath, and arbitrates the neighbour-table read port
// between updates and the route-lookup reader.
module qtable_scheduler
  import qtable_scheduler_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        pkt_valid,
  output logic                        pkt_ready,
  input  logic [WORD_WIDTH-1:0]       pkt_sourceID,
  input  logic [WORD_WIDTH-1:0]       pkt_sourceHops,
  input  logic [WORD_WIDTH-1:0]       pkt_clusterID,
  input  logic [WORD_WIDTH-1:0]       pkt_energyLeft,
  input  logic [WORD_WIDTH-1:0]       pkt_qValue,
  input  logic [WORD_WIDTH-1:0]       pkt_knownCH,
  input  logic [2:0]                  pkt_type,
  output logic                        upd_en,
  output logic [WORD_WIDTH-1:0]       upd_sourceID,
  output logic [WORD_WIDTH-1:0]       upd_sourceHops,
  output logic [WORD_WIDTH-1:0]       upd_clusterID,
  output logic [WORD_WIDTH-1:0]       upd_energyLeft,
  output logic [WORD_WIDTH-1:0]       upd_qValue,
  output logic [WORD_WIDTH-1:0]       upd_knownCH,
  output logic [2:0]                  upd_type,
  input  logic                        upd_done,
  input  logic                        rd_req,
  output logic                        rd_gnt,
  output logic                        busy,
  output logic                        err_timeout,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [WORD_WIDTH-1:0]       upd_count
);

  localparam int PW = 6 * WORD_WIDTH + 3;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [PW-1:0]         upd_pkt_q, upd_pkt_d;
  logic [WORD_WIDTH-1:0] upd_count_q, upd_count_d;
  logic                  err_q, err_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic                  fifo_wr, fifo_rd, fifo_empty;
  logic [PW-1:0]         fifo_head, pkt_flat;
  logic [CW-1:0]         fifo_cnt;

  // Flattened packet: fields from sourceID (MSBs) down to type (LSBs).
  assign pkt_flat  = {pkt_sourceID, pkt_sourceHops, pkt_clusterID,
                      pkt_energyLeft, pkt_qValue, pkt_knownCH, pkt_type};
  assign pkt_ready = (fifo_cnt < CW'(FIFO_DEPTH));
  assign fifo_wr   = pkt_valid && pkt_ready && (pkt_type != PKT_TYPE_INVALID);

  pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (pkt_flat),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_head),
    .count_o   (fifo_cnt),
    .empty_o   (fifo_empty)
  );

  // Next-state logic: buffered updates win over the reader when idle.
  always_comb begin
    state_d     = state_q;
    upd_pkt_d   = upd_pkt_q;
    upd_count_d = upd_count_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    fifo_rd     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd   = 1'b1;
          upd_pkt_d = fifo_head;
          state_d   = ST_START;
        end else if (rd_req) begin
          state_d = ST_GRANT;
        end
      end
      ST_START: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (upd_done) begin
          upd_count_d = upd_count_q + 1'b1;
          state_d     = ST_IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_GRANT: begin
        if (!rd_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, held packet fields, completion counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      upd_pkt_q   <= '0;
      upd_count_q <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      upd_pkt_q   <= upd_pkt_d;
      upd_count_q <= upd_count_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign upd_en         = (state_q == ST_START);
  assign busy           = (state_q == ST_START) || (state_q == ST_WAIT);
  assign rd_gnt         = (state_q == ST_GRANT);
  assign err_timeout    = err_q;
  assign upd_count      = upd_count_q;
  assign fifo_count     = fifo_cnt;

  assign upd_sourceID   = upd_pkt_q[PW-1                -: WORD_WIDTH];
  assign upd_sourceHops = upd_pkt_q[PW-1-WORD_WIDTH     -: WORD_WIDTH];
  assign upd_clusterID  = upd_pkt_q[PW-1-2*WORD_WIDTH   -: WORD_WIDTH];
  assign upd_energyLeft = upd_pkt_q[PW-1-3*WORD_WIDTH   -: WORD_WIDTH];
  assign upd_qValue     = upd_pkt_q[PW-1-4*WORD_WIDTH   -: WORD_WIDTH];
  assign upd_knownCH    = upd_pkt_q[PW-1-5*WORD_WIDTH   -: WORD_WIDTH];
  assign upd_type       = upd_pkt_q[2:0];

endmodule

// File: tb/tb_qtable_scheduler.sv
// Directed bench for qtable_scheduler with a queue-based reference model.
module tb_qtable_scheduler;
  import qtable_scheduler_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 255;

  logic          clk = 1'b0;
  logic          nrst, pkt_valid, upd_done, rd_req;
  logic [W-1:0]  pkt_sourceID, pkt_sourceHops, pkt_clusterID;
  logic [W-1:0]  pkt_energyLeft, pkt_qValue, pkt_knownCH;
  logic [2:0]    pkt_type;
  logic          pkt_ready, upd_en, rd_gnt, busy, err_timeout;
  logic [W-1:0]  upd_sourceID, upd_sourceHops, upd_clusterID;
  logic [W-1:0]  upd_energyLeft, upd_qValue, upd_knownCH, upd_count;
  logic [2:0]    upd_type;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  qtable_scheduler #(.WORD_WIDTH(W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_sourceID(pkt_sourceID), .pkt_sourceHops(pkt_sourceHops),
    .pkt_clusterID(pkt_clusterID), .pkt_energyLeft(pkt_energyLeft),
    .pkt_qValue(pkt_qValue), .pkt_knownCH(pkt_knownCH), .pkt_type(pkt_type),
    .upd_en(upd_en), .upd_sourceID(upd_sourceID), .upd_sourceHops(upd_sourceHops),
    .upd_clusterID(upd_clusterID), .upd_energyLeft(upd_energyLeft),
    .upd_qValue(upd_qValue), .upd_knownCH(upd_knownCH), .upd_type(upd_type),
    .upd_done(upd_done), .rd_req(rd_req), .rd_gnt(rd_gnt), .busy(busy),
    .err_timeout(err_timeout), .fifo_count(fifo_count), .upd_count(upd_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet queue plus the phase of the current job.
  pkt_t         mq[$];
  pkt_t         m_cur;
  bit           m_pulse, m_wait, m_grant, m_err;
  int           m_wait_n;
  logic [W-1:0] m_cnt;
  bit           check_en = 1'b0;

  function automatic pkt_t in_pkt();
    pkt_t p;
    p.sourceID   = pkt_sourceID;
    p.sourceHops = pkt_sourceHops;
    p.clusterID  = pkt_clusterID;
    p.energyLeft = pkt_energyLeft;
    p.qValue     = pkt_qValue;
    p.knownCH    = pkt_knownCH;
    p.ptype      = pkt_type;
    return p;
  endfunction

  task automatic model_step();
    bit take;
    pkt_t p;
    if (!nrst) begin
      mq.delete();
      m_cur = '0; m_pulse = 0; m_wait = 0; m_grant = 0; m_err = 0;
      m_wait_n = 0; m_cnt = '0;
      return;
    end
    take = pkt_valid && (mq.size() < DEPTH) && (pkt_type != PKT_TYPE_INVALID);
    p = in_pkt();
    if (m_pulse) begin
      m_pulse = 0; m_wait = 1; m_wait_n = 0;
    end else if (m_wait) begin
      if (upd_done) begin
        m_wait = 0; m_cnt = m_cnt + 16'd1;
      end else begin
        m_wait_n++;
        if (m_wait_n == TMO) begin
          m_wait = 0; m_err = 1;
        end
      end
    end else if (m_grant) begin
      if (!rd_req) m_grant = 0;
    end else if (mq.size() > 0) begin
      m_cur = mq.pop_front(); m_pulse = 1;
    end else if (rd_req) begin
      m_grant = 1;
    end
    if (take) mq.push_back(p);
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_upd_en",      32'(upd_en),         32'(m_pulse));
      chk("m_busy",        32'(busy),           32'(m_pulse || m_wait));
      chk("m_rd_gnt",      32'(rd_gnt),         32'(m_grant));
      chk("m_err_timeout", 32'(err_timeout),    32'(m_err));
      chk("m_fifo_count",  32'(fifo_count),     32'(mq.size()));
      chk("m_pkt_ready",   32'(pkt_ready),      32'(mq.size() < DEPTH));
      chk("m_upd_count",   32'(upd_count),      32'(m_cnt));
      chk("m_sourceID",    32'(upd_sourceID),   32'(m_cur.sourceID));
      chk("m_sourceHops",  32'(upd_sourceHops), 32'(m_cur.sourceHops));
      chk("m_clusterID",   32'(upd_clusterID),  32'(m_cur.clusterID));
      chk("m_energyLeft",  32'(upd_energyLeft), 32'(m_cur.energyLeft));
      chk("m_qValue",      32'(upd_qValue),     32'(m_cur.qValue));
      chk("m_knownCH",     32'(upd_knownCH),    32'(m_cur.knownCH));
      chk("m_type",        32'(upd_type),       32'(m_cur.ptype));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_fields(input logic [W-1:0] id, input logic [W-1:0] hops,
                            input logic [W-1:0] cl, input logic [W-1:0] en,
                            input logic [W-1:0] q, input logic [W-1:0] kch,
                            input logic [2:0] t);
    pkt_sourceID = id; pkt_sourceHops = hops; pkt_clusterID = cl;
    pkt_energyLeft = en; pkt_qValue = q; pkt_knownCH = kch; pkt_type = t;
  endtask

  task automatic set_pkt(input logic [W-1:0] id, input logic [2:0] t);
    set_fields(id, id + 16'd1, id + 16'd2, id ^ 16'h8000, id + 16'h3000, id + 16'd14, t);
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    while (upd_en !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk(name, 32'(upd_en), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int gnt_n;
    bit en_seen;

    nrst = 1'b0; pkt_valid = 1'b0; upd_done = 1'b0; rd_req = 1'b0;
    set_fields('0, '0, '0, '0, '0, '0, 3'b000);
    check_en = 1'b1;
    tick(); tick();
    chk("rst_upd_en", 32'(upd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_pkt_ready", 32'(pkt_ready), 32'd1);
    nrst = 1'b1;
    tick();

    // Single packet: upd_en two cycles after acceptance, done 10 cycles later.
    set_fields(16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 16'd15, 3'b101);
    pkt_valid = 1'b1;
    chk("t1_ready", 32'(pkt_ready), 32'd1);
    tick();
    pkt_valid = 1'b0;
    chk("t1_en_plus1", 32'(upd_en), 32'd0);
    tick();
    chk("t1_en_plus2", 32'(upd_en), 32'd1);
    chk("t1_src", 32'(upd_sourceID), 32'd1);
    chk("t1_hops", 32'(upd_sourceHops), 32'd2);
    chk("t1_cluster", 32'(upd_clusterID), 32'd2);
    chk("t1_energy", 32'(upd_energyLeft), 32'h8000);
    chk("t1_q", 32'(upd_qValue), 32'h3000);
    chk("t1_kch", 32'(upd_knownCH), 32'd15);
    chk("t1_type", 32'(upd_type), 32'd5);
    repeat (9) tick();
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    chk("t1_count", 32'(upd_count), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);

    // Back-to-back packets with done withheld, then in-order drain.
    for (int i = 0; i < 5; i++) begin
      set_pkt(16'(1 + 16 * i), 3'b011);
      pkt_valid = 1'b1;
      tick();
    end
    pkt_valid = 1'b0;
    chk("t2_full_count", 32'(fifo_count), 32'd4);
    chk("t2_full_ready", 32'(pkt_ready), 32'd0);
    chk("t2_head_src", 32'(upd_sourceID), 32'd1);
    set_pkt(16'd81, 3'b011);
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    chk("t2_reject_count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      upd_done = 1'b1;
      tick();
      upd_done = 1'b0;
      wait_en("t2_drain_en");
      chk("t2_order", 32'(upd_sourceID), 32'(17 + 16 * i));
      tick();
    end
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    chk("t2_empty", 32'(fifo_count), 32'd0);
    chk("t2_count", 32'(upd_count), 32'd6);

    // Contention: buffered update beats a simultaneous read request.
    set_pkt(16'h0100, 3'b010);
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    rd_req = 1'b1;
    tick();
    chk("t3_en", 32'(upd_en), 32'd1);
    chk("t3_gnt_start", 32'(rd_gnt), 32'd0);
    repeat (3) tick();
    chk("t3_gnt_wait", 32'(rd_gnt), 32'd0);
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    rd_req = 1'b0;
    tick();
    chk("t3_gnt_idle", 32'(rd_gnt), 32'd0);
    gnt_n = 0;
    rd_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) set_pkt(16'h0200, 3'b100);
      pkt_valid = (k == 2);
      tick();
      if (rd_gnt) gnt_n++;
    end
    pkt_valid = 1'b0;
    chk("t3_pending", 32'(fifo_count), 32'd1);
    chk("t3_no_en", 32'(upd_en), 32'd0);
    rd_req = 1'b0;
    tick();
    if (rd_gnt) gnt_n++;
    chk("t3_gnt_cycles", 32'(gnt_n), 32'd8);
    wait_en("t3_late_en");
    chk("t3_late_src", 32'(upd_sourceID), 32'h0200);
    tick();
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    chk("t3_count", 32'(upd_count), 32'd8);

    // Timeout: done never arrives.
    set_pkt(16'h0300, 3'b110);
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    wait_en("t4_en");
    tick();
    n = 0;
    while (busy && n < 300) begin
      n++;
      tick();
    end
    chk("t4_wait_cycles", 32'(n), 32'd255);
    chk("t4_err", 32'(err_timeout), 32'd1);
    chk("t4_count", 32'(upd_count), 32'd8);
    chk("t4_busy", 32'(busy), 32'd0);

    // Invalid packet type is taken but dropped.
    set_pkt(16'h0400, 3'b000);
    pkt_valid = 1'b1;
    chk("t5_ready", 32'(pkt_ready), 32'd1);
    tick();
    pkt_valid = 1'b0;
    chk("t5_count", 32'(fifo_count), 32'd0);
    en_seen = 1'b0;
    repeat (4) begin
      tick();
      if (upd_en) en_seen = 1'b1;
    end
    chk("t5_no_en", 32'(en_seen), 32'd0);

    // Reset during WAIT with two packets buffered.
    set_pkt(16'h0500, 3'b001);
    pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    wait_en("t6_en");
    tick();
    set_pkt(16'h0510, 3'b010);
    pkt_valid = 1'b1;
    tick();
    set_pkt(16'h0520, 3'b011);
    tick();
    pkt_valid = 1'b0;
    chk("t6_buffered", 32'(fifo_count), 32'd2);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("t6_upd_en", 32'(upd_en), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rd_gnt", 32'(rd_gnt), 32'd0);
    chk("t6_err", 32'(err_timeout), 32'd0);
    chk("t6_fifo_count", 32'(fifo_count), 32'd0);
    chk("t6_upd_count", 32'(upd_count), 32'd0);
    chk("t6_src", 32'(upd_sourceID), 32'd0);
    chk("t6_type", 32'(upd_type), 32'd0);
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    chk("t6_late_done", 32'(upd_count), 32'd0);
    en_seen = 1'b0;
    repeat (3) begin
      tick();
      if (upd_en) en_seen = 1'b1;
    end
    chk("t6_no_en", 32'(en_seen), 32'd0);

    // Reset while the reader holds the port.
    rd_req = 1'b1;
    tick(); tick();
    chk("t7_gnt", 32'(rd_gnt), 32'd1);
    nrst = 1'b0;
    rd_req = 1'b0;
    tick();
    nrst = 1'b1;
    chk("t7_gnt_rst", 32'(rd_gnt), 32'd0);
    tick();
    chk("t7_gnt_after", 32'(rd_gnt), 32'd0);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
